line_buf_window_ctrl: RTL and testbench
=======================================

Name: line_buf_window_ctrl

Overview:
- Sequences the 16-deep, 12-bit line-buffer shift chain that feeds a KxK convolution window in the MNIST CNN datapath.
- Accepts a raster-order pixel stream with a valid/ready handshake and drives the buffers' shift enable.
- Tracks row and column position and flags when the buffered KxK window is complete, with a valid/ready handshake toward the MAC array.
- Sits between the previous layer's output stream and the line-buffer chain plus conv engine.

Parameters:
- IMG_W, 16, feature-map width in pixels; must equal line-buffer depth; IMG_W >= K.
- IMG_H, 16, feature-map height in rows; IMG_H >= K.
- K, 3, kernel size, in the range 2..5.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle frame start pulse; honoured only in IDLE.
- in_valid_i  in  1  upstream pixel valid.
- in_ready_o  out  1  controller can accept a pixel.
- shift_en_o  out  1  shift enable to every line buffer; equals in_valid_i & in_ready_o (combinational).
- win_valid_o  out  1  buffered KxK window is complete and stable.
- win_ready_i  in  1  conv engine consumes the window.
- win_row_o  out  $clog2(IMG_H)  output-map row of the current window.
- win_col_o  out  $clog2(IMG_W)  output-map column of the current window.
- busy_o  out  1  high from the start_i acceptance until done_o.
- done_o  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State goes to IDLE; row and col counters go to 0.
  - All outputs go to 0: in_ready_o, shift_en_o, win_valid_o, win_row_o, win_col_o, busy_o, done_o.
  - Reset asserted mid-frame aborts the frame: no done_o, window discarded. Line-buffer contents are don't-care.
- States:
  - IDLE: in_ready_o=0. start_i moves to RUN, sets busy_o=1 and clears the counters.
  - RUN: in_ready_o = !win_valid_o | win_ready_i. The buffer window must never change while an unaccepted window is presented.
  - FLUSH: entered after the shift of the last pixel (row=IMG_H-1, col=IMG_W-1). in_ready_o=0. Waits for the last window handshake.
  - DONE: one cycle; done_o=1, busy_o=0; next state IDLE.
- Counters (advance only on shift_en_o):
  - col increments and wraps to 0 at IMG_W-1.
  - On that wrap, row increments.
- Window generation:
  - On a shift of the pixel at (row, col) with row>=K-1 and col>=K-1, win_valid_o is registered high on the same clock edge.
  - Latency is one cycle after the shift, coincident with the updated buffer outputs.
  - Coordinates are registered at the same edge: win_row_o = row-(K-1), win_col_o = col-(K-1).
- Window clearing:
  - win_valid_o clears on win_valid_o & win_ready_i, unless the same cycle's shift creates a new window.
  - Simultaneous accept and new-window shift: win_valid_o stays 1 and the coordinates update.
- Pixels with col<K-1 or row<K-1 shift in but produce no window; row wrap needs no special handling.
- Window count per frame is (IMG_H-K+1)*(IMG_W-K+1), which is 196 at defaults.
- start_i outside IDLE is ignored. in_valid_i outside RUN is ignored, with no shift.

Optional Feature:
- Macro: LINE_BUF_WIN_STRIDE2_EN.
- Defined: stride 2.
  - win_valid_o asserts only when (row-(K-1)) and (col-(K-1)) are both even.
  - win_row_o and win_col_o report those differences divided by 2.
  - Window count is ceil((IMG_H-K+1)/2)*ceil((IMG_W-K+1)/2), which is 49 at defaults.
  - Pixels shift as normal.
- Undefined: stride 1 as described above.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle while in RUN with win_valid_o=1 -> all outputs 0 immediately. A subsequent start_i restarts with the counters at 0.
- Full frame, defaults: in_valid_i=1 and win_ready_i=1 continuously -> 256 shift_en_o pulses.
  - First win_valid_o appears one cycle after the 35th shift, with (0,0).
  - Exactly 196 windows, in raster order.
  - done_o pulses once; busy_o falls in the same cycle.
- Backpressure: hold win_ready_i=0 for 5 cycles while win_valid_o=1 at (4,7) -> in_ready_o=0 and shift_en_o=0 throughout, (4,7) stable. Release -> next window (4,8).
- Row boundary: the window after (1,13) is (2,0). Shifts of pixel col 0 and col 1 of input row 4 produce no win_valid_o.
- Protocol edges:
  - start_i during RUN -> no effect.
  - in_valid_i toggled 1-0-1 with win_ready_i=1 -> counters advance only on shift cycles.
  - Last window held 3 cycles in FLUSH, then accepted -> done_o on the next cycle.
- LINE_BUF_WIN_STRIDE2_EN defined: full frame -> 49 windows, coordinates (0,0)..(6,6), first window after the 35th shift, done_o once.

Source files
------------

// File: rtl/line_buf_window_ctrl.sv
// line_buf_window_ctrl
//   Sequences the line-buffer shift chain that feeds a KxK convolution window.
//   Takes a raster-order pixel stream (valid/ready), pulses the shared shift
//   enable, tracks the row/column of the pixel being shifted, and presents a
//   registered "window complete" flag with its output-map coordinates toward
//   the MAC array (valid/ready).
//
//   Optional build macro: LINE_BUF_WIN_STRIDE2_EN selects stride-2 window
//   generation (windows only at even output offsets, coordinates halved).
//   Undefined: stride 1.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active high
//   start_i      frame start pulse, honoured only while idle
//   in_valid_i   upstream pixel valid
//   in_ready_o   controller accepts a pixel this cycle
//   shift_en_o   shift enable to every line buffer (in_valid_i & in_ready_o)
//   win_valid_o  buffered KxK window complete and stable
//   win_ready_i  conv engine consumes the window
//   win_row_o    output-map row of the presented window
//   win_col_o    output-map column of the presented window
//   busy_o       frame in progress
//   done_o       one-cycle pulse at frame completion
module line_buf_window_ctrl #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int K     = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic                     shift_en_o,
    output logic                     win_valid_o,
    input  logic                     win_ready_i,
    output logic [$clog2(IMG_H)-1:0] win_row_o,
    output logic [$clog2(IMG_W)-1:0] win_col_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] RowFirst = RW'(K - 1);
    localparam logic [CW-1:0] ColFirst = CW'(K - 1);
    localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;

    logic          in_ready;
    logic          shift;
    logic          last_pix;
    logic          win_hit;
    logic [RW-1:0] row_off;
    logic [CW-1:0] col_off;
    logic [RW-1:0] row_win;
    logic [CW-1:0] col_win;

    // Offset of the pixel being shifted relative to the first full window.
    assign row_off  = row_q - RowFirst;
    assign col_off  = col_q - ColFirst;
    assign last_pix = (row_q == RowLast) && (col_q == ColLast);

`ifdef LINE_BUF_WIN_STRIDE2_EN
    assign win_hit = (row_q >= RowFirst) && (col_q >= ColFirst) && !row_off[0] && !col_off[0];
    assign row_win = row_off >> 1;
    assign col_win = col_off >> 1;
`else
    assign win_hit = (row_q >= RowFirst) && (col_q >= ColFirst);
    assign row_win = row_off;
    assign col_win = col_off;
`endif

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        in_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StRun;
                    row_d       = '0;
                    col_d       = '0;
                    win_valid_d = 1'b0;
                end
            end
            StRun: begin
                // Never shift while an unaccepted window is presented.
                in_ready = !win_valid_q || win_ready_i;
                if (in_valid_i && in_ready && last_pix) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!win_valid_q || win_ready_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        shift = in_valid_i && in_ready;

        if (win_valid_q && win_ready_i) begin
            win_valid_d = 1'b0;
        end

        if (shift) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // A new window overrides the clear from a same-cycle accept.
            if (win_hit) begin
                win_valid_d = 1'b1;
                win_row_d   = row_win;
                win_col_d   = col_win;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign shift_en_o  = shift;
    assign win_valid_o = win_valid_q;
    assign win_row_o   = win_row_q;
    assign win_col_o   = win_col_q;
    assign busy_o      = (state_q == StRun) || (state_q == StFlush);
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_line_buf_window_ctrl.sv
// tb_line_buf_window_ctrl
//   Self-checking bench for line_buf_window_ctrl. Stimulus drives frames with
//   continuous, random and directed backpressure traffic plus a mid-frame
//   reset; a monitor keeps a raster-order reference model and a queue of
//   expected windows and compares the DUT outputs every cycle.
//   Honours LINE_BUF_WIN_STRIDE2_EN for the stride-2 build.
module tb_line_buf_window_ctrl;

    localparam int IMG_W = 16;
    localparam int IMG_H = 16;
    localparam int K     = 3;
    localparam int TOTAL = IMG_W * IMG_H;
`ifdef LINE_BUF_WIN_STRIDE2_EN
    localparam int STRIDE = 2;
    localparam int BP_R   = 2;
    localparam int BP_C   = 3;
`else
    localparam int STRIDE = 1;
    localparam int BP_R   = 4;
    localparam int BP_C   = 7;
`endif
    localparam int EXP_WINS = ((IMG_H - K) / STRIDE + 1) * ((IMG_W - K) / STRIDE + 1);

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic                     shift_en;
    logic                     win_valid;
    logic                     win_ready;
    logic [$clog2(IMG_H)-1:0] win_row;
    logic [$clog2(IMG_W)-1:0] win_col;
    logic                     busy;
    logic                     done;

    line_buf_window_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .shift_en_o  (shift_en),
        .win_valid_o (win_valid),
        .win_ready_i (win_ready),
        .win_row_o   (win_row),
        .win_col_o   (win_col),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
    } win_t;

    win_t exp_q[$];
    int   errors;
    int   checks;
    int   tmo_cnt;
    bit   end_req;

    // Reference model state (monitor-owned)
    bit   running;
    bit   flushing;
    bit   exp_done;
    bit   next_done;
    bit   mdl_wv;
    bit   exp_ready;
    bit   exp_shift;
    int   pix_cnt;
    int   win_cnt;
    int   pr;
    int   pc;
    win_t w;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        running  = 1'b0;
        flushing = 1'b0;
        exp_done = 1'b0;
        mdl_wv   = 1'b0;
        pix_cnt  = 0;
        win_cnt  = 0;
        exp_q.delete();
    endtask

    // Monitor / scoreboard
    initial begin
        errors = 0;
        checks = 0;
        model_clear();
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                check("rst_in_ready", int'(in_ready), 0);
                check("rst_shift_en", int'(shift_en), 0);
                check("rst_win_valid", int'(win_valid), 0);
                check("rst_win_row", int'(win_row), 0);
                check("rst_win_col", int'(win_col), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                model_clear();
            end else if (end_req) begin
                check("timeouts", tmo_cnt, 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else begin
                exp_ready = running && !flushing && (!mdl_wv || win_ready);
                exp_shift = in_valid && exp_ready;
                check("busy", int'(busy), int'(running));
                check("done", int'(done), int'(exp_done));
                check("in_ready", int'(in_ready), int'(exp_ready));
                check("shift_en", int'(shift_en), int'(exp_shift));
                check("win_valid", int'(win_valid), int'(mdl_wv));

                if (exp_done) begin
                    check("frame_windows", win_cnt, EXP_WINS);
                    check("frame_shifts", pix_cnt, TOTAL);
                    check("frame_leftover", exp_q.size(), 0);
                end

                if (win_valid && win_ready) begin
                    if (exp_q.size() == 0) begin
                        check("win_unexpected", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("win_row", int'(win_row), w.r);
                        check("win_col", int'(win_col), w.c);
                    end
                    win_cnt++;
                end

                // Advance the model to the next cycle
                next_done = running && flushing && (!mdl_wv || win_ready);
                if (mdl_wv && win_ready) mdl_wv = 1'b0;
                if (exp_shift) begin
                    pr = pix_cnt / IMG_W;
                    pc = pix_cnt % IMG_W;
                    if (pr >= K - 1 && pc >= K - 1 &&
                        (pr - (K - 1)) % STRIDE == 0 && (pc - (K - 1)) % STRIDE == 0) begin
                        exp_q.push_back('{r: (pr - (K - 1)) / STRIDE, c: (pc - (K - 1)) / STRIDE});
                        mdl_wv = 1'b1;
                    end
                    pix_cnt++;
                    if (pix_cnt == TOTAL) flushing = 1'b1;
                end
                if (start && !running && !exp_done) begin
                    running  = 1'b1;
                    flushing = 1'b0;
                    pix_cnt  = 0;
                    win_cnt  = 0;
                    mdl_wv   = 1'b0;
                    exp_q.delete();
                end
                exp_done = next_done;
                if (next_done) running = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) tmo_cnt++;
    endtask

    task automatic run_random(input int budget);
        int n;
        bit bp_done;
        bit fl_done;
        n       = 0;
        bp_done = 1'b0;
        fl_done = 1'b0;
        while (!done && n < budget) begin
            if (!bp_done && win_valid && int'(win_row) == BP_R && int'(win_col) == BP_C) begin
                bp_done   = 1'b1;
                in_valid  = 1'b1;
                win_ready = 1'b0;
                repeat (5) tick();
                win_ready = 1'b1;
            end else if (!fl_done && pix_cnt == TOTAL && win_valid) begin
                fl_done   = 1'b1;
                win_ready = 1'b0;
                in_valid  = 1'b1;
                repeat (3) tick();
                win_ready = 1'b1;
            end else begin
                in_valid  = ($urandom_range(0, 3) != 0);
                win_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
        end
        if (!done) tmo_cnt++;
    endtask

    // Stimulus
    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        tmo_cnt   = 0;
        end_req   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Frame A: continuous traffic, stray start while running
        pulse_start();
        in_valid  = 1'b1;
        win_ready = 1'b1;
        repeat (40) tick();
        pulse_start();
        wait_done(400);
        in_valid = 1'b0;
        tick();

        // Frame B: random traffic, directed backpressure and flush hold
        pulse_start();
        run_random(3000);
        in_valid = 1'b0;
        tick();

        // Frame C: aborted by an asynchronous reset while a window is held
        pulse_start();
        in_valid  = 1'b1;
        win_ready = 1'b0;
        n = 0;
        while (!win_valid && n < 100) begin
            tick();
            n++;
        end
        if (!win_valid) tmo_cnt++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        // Frame D: restart after reset with random traffic
        pulse_start();
        run_random(3000);
        in_valid  = 1'b0;
        win_ready = 1'b0;
        repeat (3) tick();
        end_req = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: summary not reached, got no finish expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
